// File: rtl/updown_ctrl_pkg.sv
// Shared types and constants for the pushbutton-driven up/down counter command generator.
package updown_ctrl_pkg;

    typedef enum logic {
        StManual = 1'b0,
        StRun    = 1'b1
    } state_e;

    // 10 ms debounce and 0.5 s run-mode step at 100 MHz
    localparam int unsigned DefDebCycles = 1000000;
    localparam int unsigned DefRateDiv   = 50000000;

    localparam logic DirUp   = 1'b1;
    localparam logic DirDown = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw pushbutton; emits a one-cycle pulse on each accepted press.
module btn_debounce
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DefDebCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/updown_ctrl.sv
// Turns up/down/run pushbuttons into registered En/Ud commands for a one-digit up/down counter.
module updown_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DefDebCycles,
    parameter int unsigned RATE_DIV   = DefRateDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_run,
    output logic En,
    output logic Ud,
    output logic run
);

    localparam int unsigned PreW = $clog2(RATE_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(RATE_DIV - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end
    if (RATE_DIV < 2) begin : g_bad_rate
        $error("RATE_DIV must be at least 2");
    end

    logic       up_press, dn_press, run_press;
    logic [2:0] unused_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .level   (unused_level[0]),
        .press   (up_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dn),
        .level   (unused_level[1]),
        .press   (dn_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_run),
        .level   (unused_level[2]),
        .press   (run_press)
    );

    state_e          state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            en_q, en_d;
    logic            ud_q, ud_d;
    logic            one_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StManual;
            presc_q <= '0;
            en_q    <= 1'b0;
            ud_q    <= DirUp;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            en_q    <= en_d;
            ud_q    <= ud_d;
        end
    end

    // Simultaneous up+down presses cancel out.
    assign one_dir = up_press ^ dn_press;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        ud_d    = ud_q;
        unique case (state_q)
            StManual: begin
                if (run_press) begin
                    state_d = StRun;
                    presc_d = '0;
                end else if (one_dir && !en_q) begin
                    // Back-to-back presses on adjacent cycles are dropped to keep En a pulse.
                    ud_d = up_press ? DirUp : DirDown;
                    en_d = 1'b1;
                end
            end
            StRun: begin
                if (run_press) begin
                    state_d = StManual;
                    presc_d = '0;
                end else begin
                    if (presc_q == PreMax) begin
                        presc_d = '0;
                        en_d    = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (one_dir) begin
                        ud_d = up_press ? DirUp : DirDown;
                    end
                end
            end
            default: begin
                state_d = StManual;
                presc_d = '0;
            end
        endcase
    end

    assign En  = en_q;
    assign Ud  = ud_q;
    assign run = (state_q == StRun);

endmodule
